// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester handshake and external byte-bus signals of the arbiter
interface mem_bus_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [23:0] addr0;
   logic [23:0] addr1;
   logic [7:0]  wdata0;
   logic [7:0]  wdata1;
   logic        ack0;
   logic        ack1;
   logic [7:0]  rdata;
   logic [7:0]  bus_lo;
   logic [7:0]  bus_hi;
   logic [7:0]  bus_in;
   logic        busy;
   logic        owner;

   modport master (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_in,
      output ack0, ack1, rdata, bus_lo, bus_hi, busy, owner
   );

   modport slave (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_in,
      input  ack0, ack1, rdata, bus_lo, bus_hi, busy, owner
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port arbiter sequencing byte transfers over the external memory bus
module mem_bus_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_arbiter_if.master bus
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, TURN, SAMPLE, DATA, ACK} state_t;

   state_t      state;
   logic [3:0]  starve_cnt;
   logic        last_grant;
   logic        cur_we;
   logic [7:0]  cur_addr_top;
   logic [7:0]  cur_wdata;
   logic        ack0_q;
   logic        ack1_q;
   logic        busy_q;
   logic        owner_q;
   logic [7:0]  rdata_q;
   logic [7:0]  lo_q;
   logic [7:0]  hi_q;
   logic        any_req;
   logic        grant1;
   logic [23:0] win_addr;

   // pick the winner among the requests seen in the IDLE cycle
   always_comb begin
      any_req = bus.req0 | bus.req1;
      grant1  = bus.req1;
      if (bus.req0 && bus.req1) begin
         if (PRIORITY_MODE == 0) begin
            grant1 = ~last_grant;
         end else begin
            grant1 = (starve_cnt != LIMIT);
         end
      end
      win_addr = grant1 ? bus.addr1 : bus.addr0;
   end

   // transfer sequencer; every output is registered alongside the state it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         starve_cnt   <= 4'd0;
         last_grant   <= 1'b1;
         cur_we       <= 1'b0;
         cur_addr_top <= 8'h00;
         cur_wdata    <= 8'h00;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         owner_q      <= 1'b0;
         rdata_q      <= 8'h00;
         lo_q         <= 8'h00;
         hi_q         <= 8'h00;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state        <= ADDR_LO;
                  owner_q      <= grant1;
                  last_grant   <= grant1;
                  busy_q       <= 1'b1;
                  cur_we       <= grant1 ? bus.we1 : bus.we0;
                  cur_wdata    <= grant1 ? bus.wdata1 : bus.wdata0;
                  cur_addr_top <= win_addr[23:16];
                  lo_q         <= win_addr[7:0];
                  hi_q         <= win_addr[15:8];
                  if (!grant1) begin
                     starve_cnt <= 4'd0;
                  end else if (bus.req0 && starve_cnt < LIMIT) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end else begin
                  busy_q <= 1'b0;
                  lo_q   <= 8'h00;
                  hi_q   <= 8'h00;
               end
            end
            ADDR_LO: begin
               state <= ADDR_HI;
               lo_q  <= cur_addr_top;
               hi_q  <= cur_we ? 8'hFF : 8'h00;
            end
            ADDR_HI: begin
               if (cur_we) begin
                  state <= DATA;
                  lo_q  <= cur_wdata;
                  hi_q  <= 8'hFF;
               end else begin
                  state <= TURN;
                  lo_q  <= 8'h00;
                  hi_q  <= 8'h00;
               end
            end
            TURN: begin
               state <= SAMPLE;
               lo_q  <= 8'h00;
               hi_q  <= 8'h00;
            end
            SAMPLE: begin
               state   <= ACK;
               rdata_q <= bus.bus_in;
               ack0_q  <= ~owner_q;
               ack1_q  <= owner_q;
               lo_q    <= 8'h00;
               hi_q    <= 8'h00;
            end
            DATA: begin
               state  <= ACK;
               ack0_q <= ~owner_q;
               ack1_q <= owner_q;
               lo_q   <= 8'h00;
               hi_q   <= 8'h00;
            end
            ACK: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               lo_q   <= 8'h00;
               hi_q   <= 8'h00;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               lo_q   <= 8'h00;
               hi_q   <= 8'h00;
            end
         endcase
      end
   end

   assign bus.ack0   = ack0_q;
   assign bus.ack1   = ack1_q;
   assign bus.rdata  = rdata_q;
   assign bus.bus_lo = lo_q;
   assign bus.bus_hi = hi_q;
   assign bus.busy   = busy_q;
   assign bus.owner  = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter in round-robin and fixed-priority modes
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [23:0] addr0 = '0, addr1 = '0;
   logic [7:0]  wdata0 = '0, wdata1 = '0, bus_in = '0;
   logic [7:0]  hist [int];

   mem_bus_arbiter_if bif_rr ();
   mem_bus_arbiter_if bif_fx ();

   assign bif_rr.req0 = req0 & ~sel;
   assign bif_rr.req1 = req1 & ~sel;
   assign bif_fx.req0 = req0 & sel;
   assign bif_fx.req1 = req1 & sel;
   assign bif_rr.we0 = we0;       assign bif_fx.we0 = we0;
   assign bif_rr.we1 = we1;       assign bif_fx.we1 = we1;
   assign bif_rr.addr0 = addr0;   assign bif_fx.addr0 = addr0;
   assign bif_rr.addr1 = addr1;   assign bif_fx.addr1 = addr1;
   assign bif_rr.wdata0 = wdata0; assign bif_fx.wdata0 = wdata0;
   assign bif_rr.wdata1 = wdata1; assign bif_fx.wdata1 = wdata1;
   assign bif_rr.bus_in = bus_in; assign bif_fx.bus_in = bus_in;

   mem_bus_arbiter #(.PRIORITY_MODE(0), .STARVE_LIMIT(4)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bif_rr));
   mem_bus_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(2)) dut_fx (.clk(clk), .rst_n(rst_n), .bus(bif_fx));

   logic [7:0] m_lo, m_hi, m_rdata;
   logic       m_ack0, m_ack1, m_busy, m_owner;
   assign m_lo    = sel ? bif_fx.bus_lo : bif_rr.bus_lo;
   assign m_hi    = sel ? bif_fx.bus_hi : bif_rr.bus_hi;
   assign m_rdata = sel ? bif_fx.rdata  : bif_rr.rdata;
   assign m_ack0  = sel ? bif_fx.ack0   : bif_rr.ack0;
   assign m_ack1  = sel ? bif_fx.ack1   : bif_rr.ack1;
   assign m_busy  = sel ? bif_fx.busy   : bif_rr.busy;
   assign m_owner = sel ? bif_fx.owner  : bif_rr.owner;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int              port;
      int              s;
      int              len;
      bit              rd;
      logic [4:0][7:0] lo;
      logic [4:0][7:0] hi;
   } txn_t;
   txn_t q[$];

   bit          pend[2];
   bit          p_we[2];
   logic [23:0] p_addr[2];
   logic [7:0]  p_wd[2];
   int          m_last[2];
   int          m_starve[2];
   int          lim[2] = '{4, 2};
   bit          in_ack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // fresh read-data byte every cycle, remembered per cycle for the scoreboard
   always @(posedge clk) begin
      #2;
      bus_in = 8'($urandom);
      hist[cyc] = bus_in;
   end

   // monitor: every cycle the bus either belongs to the front transaction or must be idle
   always @(negedge clk) begin
      int k;
      bit lst;
      if (rst_n) begin
         chk("ack_exclusive", 32'(m_ack0 & m_ack1), 0);
         if (q.size() > 0 && cyc >= q[0].s && cyc < q[0].s + q[0].len) begin
            k   = cyc - q[0].s;
            lst = (k == q[0].len - 1);
            chk("bus_lo", 32'(m_lo), 32'(q[0].lo[k]));
            chk("bus_hi", 32'(m_hi), 32'(q[0].hi[k]));
            chk("busy", 32'(m_busy), 1);
            chk("owner", 32'(m_owner), q[0].port);
            chk("ack0", 32'(m_ack0), 32'(lst && q[0].port == 0));
            chk("ack1", 32'(m_ack1), 32'(lst && q[0].port == 1));
            if (lst) begin
               if (q[0].rd) chk("rdata", 32'(m_rdata), 32'(hist[q[0].s + 3]));
               void'(q.pop_front());
            end
         end else begin
            chk("idle_lo", 32'(m_lo), 0);
            chk("idle_hi", 32'(m_hi), 0);
            chk("idle_busy", 32'(m_busy), 0);
            chk("idle_ack", 32'({m_ack0, m_ack1}), 0);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic drive();
      req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
      req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
   endtask

   task automatic set_req(input int p, input bit we, input logic [23:0] a, input logic [7:0] d);
      pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
   endtask

   task automatic rand_req(input int p);
      set_req(p, 1'($urandom), 24'($urandom), 8'($urandom));
   endtask

   function automatic int pick();
      if (pend[0] && pend[1]) begin
         if (sel == 1'b0) return (m_last[0] == 1) ? 0 : 1;
         return (m_starve[1] == lim[1]) ? 0 : 1;
      end
      return pend[1] ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_last = '{1, 1};
      m_starve = '{0, 0};
   endtask

   // one arbitration + transfer; requests are already driven; returns in the ack cycle
   task automatic do_transfer(input int pulse_pct, input int rst_at);
      txn_t t;
      int w, o, ackc, si;
      si = int'(sel);
      if (in_ack) next_cycle();
      w = pick();
      o = 1 - w;
      if (w == 1 && pend[0] && m_starve[si] < lim[si]) m_starve[si]++;
      if (w == 0) m_starve[si] = 0;
      m_last[si] = w;
      t.port = w; t.s = cyc + 1; t.rd = !p_we[w]; t.lo = '0; t.hi = '0;
      t.lo[0] = p_addr[w][7:0];
      t.hi[0] = p_addr[w][15:8];
      t.lo[1] = p_addr[w][23:16];
      if (p_we[w]) begin
         t.hi[1] = 8'hFF; t.lo[2] = p_wd[w]; t.hi[2] = 8'hFF; t.len = 4;
      end else begin
         t.len = 5;
      end
      q.push_back(t);
      ackc = t.s + t.len - 1;
      next_cycle();
      if (rst_at >= 0) begin
         while (cyc < t.s + rst_at) next_cycle();
         rst_n = 1'b0;
         #1;
         chk("rst_bus_lo", 32'(m_lo), 0);
         chk("rst_bus_hi", 32'(m_hi), 0);
         chk("rst_busy", 32'(m_busy), 0);
         chk("rst_ack", 32'({m_ack0, m_ack1}), 0);
         q.delete();
         pend = '{0, 0};
         drive();
         model_reset();
         next_cycle();
         next_cycle();
         rst_n = 1'b1;
         in_ack = 1'b0;
         next_cycle();
         return;
      end
      if (!pend[o] && $urandom_range(0, 99) < pulse_pct) begin
         if (o == 0) req0 = 1'b1; else req1 = 1'b1;
         next_cycle();
         drive();
      end
      while (cyc < ackc) next_cycle();
      pend[w] = 1'b0;
      in_ack = 1'b1;
   endtask

   task automatic hold_both(input int n);
      for (int i = 0; i < n; i++) begin
         for (int p = 0; p < 2; p++) if (!pend[p]) rand_req(p);
         drive();
         do_transfer(0, -1);
      end
   endtask

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
         for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 2) != 0) rand_req(p);
         if (!pend[0] && !pend[1]) begin
            drive();
            if ($urandom_range(0, 1) == 1) begin
               repeat ($urandom_range(1, 3)) next_cycle();
               in_ack = 1'b0;
            end
            rand_req($urandom_range(0, 1));
         end
         drive();
         do_transfer(25, -1);
      end
   endtask

   task automatic drain();
      while (pend[0] || pend[1]) begin
         drive();
         do_transfer(0, -1);
      end
      drive();
      repeat (3) next_cycle();
      in_ack = 1'b0;
   endtask

   initial begin
      pend = '{0, 0}; p_we = '{0, 0}; p_addr = '{0, 0}; p_wd = '{0, 0};
      model_reset();
      drive();
      repeat (2) @(posedge clk);
      #3;
      chk("reset_rr_lo", 32'(bif_rr.bus_lo), 0);
      chk("reset_rr_hi", 32'(bif_rr.bus_hi), 0);
      chk("reset_rr_ack", 32'({bif_rr.ack0, bif_rr.ack1}), 0);
      chk("reset_rr_rdata", 32'(bif_rr.rdata), 0);
      chk("reset_rr_busy", 32'(bif_rr.busy), 0);
      chk("reset_rr_owner", 32'(bif_rr.owner), 0);
      chk("reset_fx_lo", 32'(bif_fx.bus_lo), 0);
      chk("reset_fx_hi", 32'(bif_fx.bus_hi), 0);
      chk("reset_fx_busy", 32'(bif_fx.busy), 0);
      chk("reset_fx_rdata", 32'(bif_fx.rdata), 0);
      rst_n = 1'b1;
      next_cycle();

      set_req(0, 1'b0, 24'h123456, 8'h00);
      drive();
      do_transfer(0, -1);
      set_req(1, 1'b1, 24'h800002, 8'h7F);
      drive();
      do_transfer(0, -1);
      set_req(1, 1'b0, 24'h00F00D, 8'h00);
      drive();
      do_transfer(100, -1);
      hold_both(4);
      drain();
      random_phase(120);
      drain();

      sel = 1'b1;
      next_cycle();
      hold_both(6);
      drain();
      random_phase(120);
      drain();

      set_req(1, 1'b1, 24'h00ABCD, 8'h3C);
      drive();
      do_transfer(0, 1);
      set_req(0, 1'b0, 24'h654321, 8'h00);
      drive();
      do_transfer(0, -1);
      drain();
      repeat (4) next_cycle();
      chk("scoreboard_empty", 32'(q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter PRIORITY_MODE, default 0, meaning 0 = round-robin and 1 = port 1 (scanout) fixed priority.
REQ-002 Parameter STARVE_LIMIT, default 4, range 1-15, meaning in fixed mode port 0 wins after this many consecutive lost arbitrations.
REQ-003 clk  input  1  the single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0, req1  input  1 each  transfer request from port 0 (renderer) and port 1 (scanout).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read.
REQ-007 addr0, addr1  input  24 each  external byte address.
REQ-008 wdata0, wdata1  input  8 each  write byte.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  8  last read byte; valid while ack0 or ack1 is high and held afterwards.
REQ-011 bus_lo  output  8  registered; drives the dedicated-output pins.
REQ-012 bus_hi  output  8  registered; drives the bidirectional pins, whose enables are tied all-ones outside this block.
REQ-013 bus_in  input  8  read data from the dedicated-input pins.
REQ-014 busy  output  1  high from the grant edge through the ACK cycle.
REQ-015 owner  output  1  index of the current or last granted port.

Function
REQ-016 States: IDLE, ADDR_LO, ADDR_HI, TURN, SAMPLE, DATA, ACK; all outputs are registered and reflect the current state.
REQ-017 IDLE: bus_lo=0x00, bus_hi=0x00; when any req is high, grant at the edge, latch the winner's we/addr/wdata, set owner, and go to ADDR_LO.
REQ-018 ADDR_LO: bus_lo=addr[7:0], bus_hi=addr[15:8]; go to ADDR_HI.
REQ-019 ADDR_HI: bus_lo=addr[23:16]; bus_hi=0xFF for a write, 0x00 for a read; go to DATA if write, TURN if read.
REQ-020 TURN: bus_lo=0x00, bus_hi=0x00; bus_in is ignored; go to SAMPLE.
REQ-021 SAMPLE: bus_lo=0x00, bus_hi=0x00; capture bus_in into rdata at the closing edge; go to ACK.
REQ-022 DATA: bus_lo=wdata, bus_hi=0xFF; go to ACK.
REQ-023 ACK: bus_lo=0x00, bus_hi=0x00; ack of the owner is high for exactly this cycle; go to IDLE; no arbitration occurs in ACK.
REQ-024 Latency from grant edge to ack: read 4 cycles, write 3 cycles; back-to-back spacing: read 6 cycles, write 5 cycles.
REQ-025 Requesters hold req/we/addr/wdata stable until ack; the arbiter samples them only at the grant edge.
REQ-026 A req deasserted before grant is dropped with no bus activity.
REQ-027 A req still high in the IDLE cycle after ack is treated as a new request.
REQ-028 Round-robin: a single requester wins; when both request, the port not granted last wins.
REQ-029 Fixed mode: port 1 wins ties, except when starve_cnt==STARVE_LIMIT, in which case port 0 wins.
REQ-030 starve_cnt (4-bit) increments when port 0 requests and loses, clears when port 0 is granted, and saturates at STARVE_LIMIT; it never wraps.
REQ-031 A req arriving during a transfer waits; the in-flight transfer is never preempted.
REQ-032 Both ack outputs are never high in the same cycle.

Reset
REQ-033 While rst_n=0, these outputs are forced immediately, independent of clk: bus_lo=0x00, bus_hi=0x00, ack0=0, ack1=0, rdata=0x00, busy=0, owner=0, state=IDLE, starve_cnt=0, last-granted=1.
REQ-034 Reset mid-transfer abandons the transfer with no ack; after release, arbitration restarts from IDLE.

Verification
REQ-035 Port0 read of addr0=0x123456 with bus_in=0xA5 during SAMPLE -> bus_lo/bus_hi sequence 56/34, 12/00, 00/00, 00/00, then ack0 with rdata=0xA5, 4 cycles after the grant edge.
REQ-036 Port1 write of addr1=0x800002, wdata1=0x7F -> bus_lo/bus_hi sequence 02/00, 80/FF, 7F/FF, then ack1; busy is high for 4 cycles.
REQ-037 Round-robin, req0 and req1 both held high for 4 transfers -> grant order 0,1,0,1 (port 0 first after reset); no cycle has both acks high.
REQ-038 Fixed mode, STARVE_LIMIT=2, both requests held high -> grant order 1,1,0,1,1,0.
REQ-039 rst_n pulled low during ADDR_HI of a write -> bus_lo, bus_hi and busy are 0 before the next clk edge; no ack is issued; a request after release completes normally.
REQ-040 req0 pulsed for 1 cycle while port 1 is busy -> no port-0 transfer and no ack0.
